// File: rtl/zigzag_pingpong.sv
// Double-buffered 8x8 coefficient reorder stage: one bank fills with row-ordered beats while the
// other drains in zigzag, transpose or raster order, one beat per cycle on each side.
module zigzag_pingpong #(
  parameter int BW = 8
) (
  input  logic            i_clk,
  input  logic            i_Reset,
  input  logic [8*BW-1:0] i_data,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [1:0]      i_mode,
  output logic [8*BW-1:0] o_data,
  output logic            o_valid,
  input  logic            i_ready,
  output logic            o_last,
  output logic [1:0]      o_mode
);

  typedef enum logic [1:0] {
    SCAN_ZIGZAG    = 2'b00,
    SCAN_TRANSPOSE = 2'b01,
    SCAN_RASTER    = 2'b10
  } scan_e;

  logic [BW-1:0] bank_q [2][64];
  scan_e         bankMode_q [2];

  logic [1:0] full_q, full_d;
  logic       wrBank_q, wrBank_d;
  logic       rdBank_q, rdBank_d;
  logic [2:0] wrRow_q, wrRow_d;
  logic [2:0] rdBeat_q, rdBeat_d;

  logic       inAccept;
  logic       outAccept;
  logic [5:0] scanPos;
  logic [5:0] flatIdx;

  function automatic scan_e toScan(input logic [1:0] mode);
    case (mode)
      2'b00:   toScan = SCAN_ZIGZAG;
      2'b01:   toScan = SCAN_TRANSPOSE;
      default: toScan = SCAN_RASTER;
    endcase
  endfunction

  // Standard JPEG zigzag order: scan position -> row-major flat index.
  function automatic logic [5:0] zigzagIndex(input logic [5:0] p);
    case (p)
      6'd0:  zigzagIndex = 6'd0;
      6'd1:  zigzagIndex = 6'd1;
      6'd2:  zigzagIndex = 6'd8;
      6'd3:  zigzagIndex = 6'd16;
      6'd4:  zigzagIndex = 6'd9;
      6'd5:  zigzagIndex = 6'd2;
      6'd6:  zigzagIndex = 6'd3;
      6'd7:  zigzagIndex = 6'd10;
      6'd8:  zigzagIndex = 6'd17;
      6'd9:  zigzagIndex = 6'd24;
      6'd10: zigzagIndex = 6'd32;
      6'd11: zigzagIndex = 6'd25;
      6'd12: zigzagIndex = 6'd18;
      6'd13: zigzagIndex = 6'd11;
      6'd14: zigzagIndex = 6'd4;
      6'd15: zigzagIndex = 6'd5;
      6'd16: zigzagIndex = 6'd12;
      6'd17: zigzagIndex = 6'd19;
      6'd18: zigzagIndex = 6'd26;
      6'd19: zigzagIndex = 6'd33;
      6'd20: zigzagIndex = 6'd40;
      6'd21: zigzagIndex = 6'd48;
      6'd22: zigzagIndex = 6'd41;
      6'd23: zigzagIndex = 6'd34;
      6'd24: zigzagIndex = 6'd27;
      6'd25: zigzagIndex = 6'd20;
      6'd26: zigzagIndex = 6'd13;
      6'd27: zigzagIndex = 6'd6;
      6'd28: zigzagIndex = 6'd7;
      6'd29: zigzagIndex = 6'd14;
      6'd30: zigzagIndex = 6'd21;
      6'd31: zigzagIndex = 6'd28;
      6'd32: zigzagIndex = 6'd35;
      6'd33: zigzagIndex = 6'd42;
      6'd34: zigzagIndex = 6'd49;
      6'd35: zigzagIndex = 6'd56;
      6'd36: zigzagIndex = 6'd57;
      6'd37: zigzagIndex = 6'd50;
      6'd38: zigzagIndex = 6'd43;
      6'd39: zigzagIndex = 6'd36;
      6'd40: zigzagIndex = 6'd29;
      6'd41: zigzagIndex = 6'd22;
      6'd42: zigzagIndex = 6'd15;
      6'd43: zigzagIndex = 6'd23;
      6'd44: zigzagIndex = 6'd30;
      6'd45: zigzagIndex = 6'd37;
      6'd46: zigzagIndex = 6'd44;
      6'd47: zigzagIndex = 6'd51;
      6'd48: zigzagIndex = 6'd58;
      6'd49: zigzagIndex = 6'd59;
      6'd50: zigzagIndex = 6'd52;
      6'd51: zigzagIndex = 6'd45;
      6'd52: zigzagIndex = 6'd38;
      6'd53: zigzagIndex = 6'd31;
      6'd54: zigzagIndex = 6'd39;
      6'd55: zigzagIndex = 6'd46;
      6'd56: zigzagIndex = 6'd53;
      6'd57: zigzagIndex = 6'd60;
      6'd58: zigzagIndex = 6'd61;
      6'd59: zigzagIndex = 6'd54;
      6'd60: zigzagIndex = 6'd47;
      6'd61: zigzagIndex = 6'd55;
      6'd62: zigzagIndex = 6'd62;
      default: zigzagIndex = 6'd63;
    endcase
  endfunction

  assign o_ready   = ~full_q[wrBank_q];
  assign o_valid   = full_q[rdBank_q];
  assign inAccept  = i_valid & o_ready;
  assign outAccept = o_valid & i_ready;
  assign o_last    = o_valid & (rdBeat_q == 3'd7);
  assign o_mode    = o_valid ? bankMode_q[rdBank_q] : 2'b00;

  // Fill and drain always target different banks, so their full-flag updates never collide.
  always_comb begin
    full_d   = full_q;
    wrBank_d = wrBank_q;
    rdBank_d = rdBank_q;
    wrRow_d  = wrRow_q;
    rdBeat_d = rdBeat_q;
    if (inAccept) begin
      wrRow_d = wrRow_q + 3'd1;
      if (wrRow_q == 3'd7) begin
        full_d[wrBank_q] = 1'b1;
        wrBank_d         = ~wrBank_q;
      end
    end
    if (outAccept) begin
      rdBeat_d = rdBeat_q + 3'd1;
      if (rdBeat_q == 3'd7) begin
        full_d[rdBank_q] = 1'b0;
        rdBank_d         = ~rdBank_q;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_Reset) begin
      full_q   <= 2'b00;
      wrBank_q <= 1'b0;
      rdBank_q <= 1'b0;
      wrRow_q  <= 3'd0;
      rdBeat_q <= 3'd0;
    end else begin
      full_q   <= full_d;
      wrBank_q <= wrBank_d;
      rdBank_q <= rdBank_d;
      wrRow_q  <= wrRow_d;
      rdBeat_q <= rdBeat_d;
    end
  end

  // Bank storage needs no reset; the scan mode is latched from the first row of each block.
  always_ff @(posedge i_clk) begin
    if (inAccept) begin
      for (int k = 0; k < 8; k++) begin
        bank_q[wrBank_q][{wrRow_q, 3'(k)}] <= i_data[(7-k)*BW +: BW];
      end
      if (wrRow_q == 3'd0) begin
        bankMode_q[wrBank_q] <= toScan(i_mode);
      end
    end
  end

  always_comb begin
    o_data  = '0;
    scanPos = '0;
    flatIdx = '0;
    if (o_valid) begin
      for (int e = 0; e < 8; e++) begin
        scanPos = {rdBeat_q, 3'(e)};
        case (bankMode_q[rdBank_q])
          SCAN_ZIGZAG:    flatIdx = zigzagIndex(scanPos);
          SCAN_TRANSPOSE: flatIdx = {3'(e), rdBeat_q};
          default:        flatIdx = scanPos;
        endcase
        o_data[(7-e)*BW +: BW] = bank_q[rdBank_q][flatIdx];
      end
    end
  end

endmodule

// File: tb/tb_zigzag_pingpong.sv
// Self-checking bench for zigzag_pingpong: random blocks are pushed through the DUT and compared
// against a block-level reference that computes each scan order directly from the 8x8 data.
module tb_zigzag_pingpong;

  localparam int BW = 8;

  logic        i_clk = 1'b0;
  logic        i_Reset;
  logic [63:0] i_data;
  logic        i_valid;
  logic        o_ready;
  logic [1:0]  i_mode;
  logic [63:0] o_data;
  logic        o_valid;
  logic        i_ready;
  logic        o_last;
  logic [1:0]  o_mode;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          zz[64];
  logic [7:0]  blkData[$];
  logic [1:0]  blkMode[$];
  time         lastRowT[64];
  int          rowsAccepted;
  int          stallCycles;

  // Collected output beats
  logic [63:0] gotData[$];
  logic        gotLast[$];
  logic [1:0]  gotMode[$];
  logic        gotORdy[$];
  time         gotT[$];
  time         firstValidT;
  int          validGaps;
  int          idleNonZero;
  int          holdBroken;

  zigzag_pingpong #(.BW(BW)) dut (
    .i_clk   (i_clk),
    .i_Reset (i_Reset),
    .i_data  (i_data),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_mode  (i_mode),
    .o_data  (o_data),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_last  (o_last),
    .o_mode  (o_mode)
  );

  always #5 i_clk = ~i_clk;

  // Walk the anti-diagonals, alternating direction, to produce the zigzag scan.
  function automatic void buildZigzag();
    int p = 0;
    for (int s = 0; s < 15; s++) begin
      int lo = (s > 7) ? s - 7 : 0;
      int hi = (s < 7) ? s : 7;
      if (s % 2 == 0) begin
        for (int r = hi; r >= lo; r--) begin zz[p] = 8*r + (s - r); p++; end
      end else begin
        for (int r = lo; r <= hi; r++) begin zz[p] = 8*r + (s - r); p++; end
      end
    end
  endfunction

  function automatic int addBlock(input logic [1:0] mode, input bit ramp);
    for (int z = 0; z < 64; z++) blkData.push_back(ramp ? 8'(z) : 8'($urandom_range(0, 255)));
    blkMode.push_back(mode);
    return blkMode.size() - 1;
  endfunction

  function automatic logic [1:0] effMode(input int blk);
    return (blkMode[blk] == 2'b11) ? 2'b10 : blkMode[blk];
  endfunction

  function automatic logic [63:0] modelBeat(input int blk, input int b);
    logic [63:0] w = '0;
    logic [1:0]  m = effMode(blk);
    for (int e = 0; e < 8; e++) begin
      int p = 8*b + e;
      int z;
      if (m == 2'b00)      z = zz[p];
      else if (m == 2'b01) z = 8*e + b;
      else                 z = p;
      w = {w[55:0], blkData[64*blk + z]};
    end
    return w;
  endfunction

  // Drives rows of consecutive model blocks; later rows carry a different i_mode on purpose.
  task automatic applyStimulus(input int firstBlk, input int nRows);
    for (int k = 0; k < nRows; k++) begin
      int blk = firstBlk + k / 8;
      int r = k % 8;
      int waitCnt = 0;
      @(negedge i_clk);
      i_valid = 1'b1;
      for (int c = 0; c < 8; c++) i_data[(7-c)*8 +: 8] = blkData[64*blk + 8*r + c];
      i_mode = (r == 0) ? blkMode[blk] : (blkMode[blk] ^ 2'($urandom_range(1, 3)));
      while (!o_ready && waitCnt < 400) begin
        @(negedge i_clk);
        waitCnt++;
        stallCycles++;
      end
      if (!o_ready) begin
        checks++;
        errors++;
        $display("[TB] FAIL input_timeout: block %0d row %0d o_ready=%0b after %0d cycles, required 1",
                 blk, r, o_ready, waitCnt);
      end
      @(posedge i_clk);
      rowsAccepted++;
      if (r == 7) lastRowT[blk] = $time;
    end
    @(negedge i_clk);
    i_valid = 1'b0;
  endtask

  // Records accepted output beats plus handshake observations; comparisons happen in each test.
  task automatic collectBeats(input int n, input int readyPct);
    int budget = 0;
    logic [63:0] heldData = '0;
    bit holding = 1'b0;
    gotData.delete(); gotLast.delete(); gotMode.delete(); gotORdy.delete(); gotT.delete();
    firstValidT = 0; validGaps = 0; idleNonZero = 0; holdBroken = 0;
    while (gotData.size() < n && budget < 3000) begin
      @(negedge i_clk);
      budget++;
      i_ready = (readyPct >= 100) ? 1'b1 : (int'($urandom_range(0, 99)) < readyPct);
      if (o_valid) begin
        if (firstValidT == 0) firstValidT = $time;
        if (holding && o_data !== heldData) holdBroken++;
        if (i_ready) begin
          gotData.push_back(o_data);
          gotLast.push_back(o_last);
          gotMode.push_back(o_mode);
          gotORdy.push_back(o_ready);
          gotT.push_back($time);
          holding = 1'b0;
        end else begin
          holding  = 1'b1;
          heldData = o_data;
        end
      end else begin
        if (firstValidT != 0) validGaps++;
        if (o_data !== '0 || o_last !== 1'b0 || o_mode !== 2'b00) idleNonZero++;
      end
    end
    if (gotData.size() < n) begin
      checks++;
      errors++;
      $display("[TB] FAIL output_timeout: got %0d beats, required %0d", gotData.size(), n);
    end
    @(posedge i_clk);
    #1 i_ready = 1'b0;
  endtask

  task automatic test_reset();
    i_Reset = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_data = '0; i_mode = 2'b00;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_Reset = 1'b1;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0b, expected 0", o_valid); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %0b, expected 1", o_ready); end
    checks++; if (o_data !== 64'h0) begin errors++; $display("[TB] FAIL reset_data: got %h, expected 0", o_data); end
    checks++; if (o_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_last: got %0b, expected 0", o_last); end
    checks++; if (o_mode !== 2'b00) begin errors++; $display("[TB] FAIL reset_mode: got %b, expected 00", o_mode); end
  endtask

  task automatic test_zigzag();
    int blk = addBlock(2'b00, 1'b1);
    fork
      applyStimulus(blk, 8);
      collectBeats(8, 100);
    join
    if (gotData.size() == 8) begin
      checks++; if (gotData[0] !== 64'h000108100902030A) begin errors++; $display("[TB] FAIL zigzag_beat0: got %h, expected 000108100902030a", gotData[0]); end
      checks++; if (gotData[7] !== 64'h353C3D362F373E3F) begin errors++; $display("[TB] FAIL zigzag_beat7: got %h, expected 353c3d362f373e3f", gotData[7]); end
    end
    for (int b = 0; b < gotData.size(); b++) begin
      checks++; if (gotData[b] !== modelBeat(blk, b)) begin errors++; $display("[TB] FAIL zigzag_data b%0d: got %h, expected %h", b, gotData[b], modelBeat(blk, b)); end
      checks++; if (gotLast[b] !== (b == 7)) begin errors++; $display("[TB] FAIL zigzag_last b%0d: got %0b, expected %0b", b, gotLast[b], (b == 7)); end
      checks++; if (gotMode[b] !== 2'b00) begin errors++; $display("[TB] FAIL zigzag_mode b%0d: got %b, expected 00", b, gotMode[b]); end
    end
    checks++; if (firstValidT !== lastRowT[blk] + 5) begin errors++; $display("[TB] FAIL zigzag_latency: first valid at %0t, expected %0t", firstValidT, lastRowT[blk] + 5); end
  endtask

  task automatic test_transpose();
    int blk = addBlock(2'b01, 1'b1);
    fork
      applyStimulus(blk, 8);
      collectBeats(8, 100);
    join
    if (gotData.size() == 8) begin
      checks++; if (gotData[0] !== 64'h0008101820283038) begin errors++; $display("[TB] FAIL transpose_beat0: got %h, expected 0008101820283038", gotData[0]); end
      checks++; if (gotData[7] !== 64'h070F171F272F373F) begin errors++; $display("[TB] FAIL transpose_beat7: got %h, expected 070f171f272f373f", gotData[7]); end
    end
    for (int b = 0; b < gotData.size(); b++) begin
      checks++; if (gotData[b] !== modelBeat(blk, b)) begin errors++; $display("[TB] FAIL transpose_data b%0d: got %h, expected %h", b, gotData[b], modelBeat(blk, b)); end
      checks++; if (gotMode[b] !== 2'b01) begin errors++; $display("[TB] FAIL transpose_mode b%0d: got %b, expected 01", b, gotMode[b]); end
    end
  endtask

  task automatic test_modes();
    int base = addBlock(2'b10, 1'b0);
    int unused1 = addBlock(2'b11, 1'b0);
    int unused2 = addBlock(2'b00, 1'b0);
    fork
      applyStimulus(base, 24);
      collectBeats(24, 70);
    join
    for (int i = 0; i < gotData.size(); i++) begin
      int blk = base + i / 8;
      checks++; if (gotData[i] !== modelBeat(blk, i % 8)) begin errors++; $display("[TB] FAIL modes_data beat%0d: got %h, expected %h", i, gotData[i], modelBeat(blk, i % 8)); end
      checks++; if (gotMode[i] !== effMode(blk)) begin errors++; $display("[TB] FAIL modes_mode beat%0d: got %b, expected %b", i, gotMode[i], effMode(blk)); end
      checks++; if (gotLast[i] !== (i % 8 == 7)) begin errors++; $display("[TB] FAIL modes_last beat%0d: got %0b, expected %0b", i, gotLast[i], (i % 8 == 7)); end
    end
    if (gotData.size() == 24) begin
      logic [63:0] row = '0;
      for (int c = 0; c < 8; c++) row = {row[55:0], blkData[64*(base+1) + 8*3 + c]};
      checks++; if (gotData[11] !== row) begin errors++; $display("[TB] FAIL mode11_raster_row3: got %h, expected %h", gotData[11], row); end
    end
    checks++; if (holdBroken !== 0) begin errors++; $display("[TB] FAIL modes_hold: got %0d changes under backpressure, expected 0", holdBroken); end
    checks++; if (idleNonZero !== 0) begin errors++; $display("[TB] FAIL modes_idle_zero: got %0d nonzero idle cycles, expected 0", idleNonZero); end
    if (unused1 + unused2 < 0) $display("[TB] unexpected block index");
  endtask

  task automatic test_back_to_back();
    int base = blkMode.size();
    for (int k = 0; k < 4; k++) begin
      int idx = addBlock(2'($urandom_range(0, 3)), 1'b0);
      if (idx != base + k) $display("[TB] unexpected block index %0d", idx);
    end
    stallCycles = 0;
    fork
      applyStimulus(base, 32);
      collectBeats(32, 100);
    join
    checks++; if (stallCycles !== 0) begin errors++; $display("[TB] FAIL b2b_ready: got %0d stall cycles, expected 0", stallCycles); end
    checks++; if (validGaps !== 0) begin errors++; $display("[TB] FAIL b2b_gaps: got %0d bubbles, expected 0", validGaps); end
    for (int i = 0; i < gotData.size(); i++) begin
      int blk = base + i / 8;
      checks++; if (gotData[i] !== modelBeat(blk, i % 8)) begin errors++; $display("[TB] FAIL b2b_data beat%0d: got %h, expected %h", i, gotData[i], modelBeat(blk, i % 8)); end
      checks++; if (gotMode[i] !== effMode(blk)) begin errors++; $display("[TB] FAIL b2b_mode beat%0d: got %b, expected %b", i, gotMode[i], effMode(blk)); end
      if (i > 0) begin
        checks++; if (gotT[i] - gotT[i-1] !== 10) begin errors++; $display("[TB] FAIL b2b_contiguous beat%0d: spacing %0t, expected 10", i, gotT[i] - gotT[i-1]); end
      end
    end
  endtask

  task automatic test_backpressure();
    int base = blkMode.size();
    for (int k = 0; k < 3; k++) begin
      int idx = addBlock(2'($urandom_range(0, 3)), 1'b0);
      if (idx != base + k) $display("[TB] unexpected block index %0d", idx);
    end
    rowsAccepted = 0;
    i_ready = 1'b0;
    fork
      applyStimulus(base, 24);
      begin
        int n = 0;
        while (rowsAccepted < 16 && n < 200) begin @(negedge i_clk); n++; end
        repeat (3) @(negedge i_clk);
        checks++; if (o_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready_low: got %0b, expected 0", o_ready); end
        checks++; if (o_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid: got %0b, expected 1", o_valid); end
        checks++; if (o_data !== modelBeat(base, 0)) begin errors++; $display("[TB] FAIL bp_data: got %h, expected %h", o_data, modelBeat(base, 0)); end
        checks++; if (o_mode !== effMode(base)) begin errors++; $display("[TB] FAIL bp_mode: got %b, expected %b", o_mode, effMode(base)); end
        repeat (4) @(negedge i_clk);
        checks++; if (o_data !== modelBeat(base, 0)) begin errors++; $display("[TB] FAIL bp_held: got %h, expected %h", o_data, modelBeat(base, 0)); end
        checks++; if (o_last !== 1'b0) begin errors++; $display("[TB] FAIL bp_last: got %0b, expected 0", o_last); end
        collectBeats(24, 100);
      end
    join
    if (gotData.size() == 24) begin
      checks++; if (gotORdy[7] !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready_at_beat7: got %0b, expected 0", gotORdy[7]); end
      checks++; if (gotORdy[8] !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready_after_free: got %0b, expected 1", gotORdy[8]); end
      checks++; if (gotT[8] - gotT[7] !== 10) begin errors++; $display("[TB] FAIL bp_spacing: got %0t, expected 10", gotT[8] - gotT[7]); end
    end
    for (int i = 0; i < gotData.size(); i++) begin
      checks++; if (gotData[i] !== modelBeat(base + i / 8, i % 8)) begin errors++; $display("[TB] FAIL bp_data beat%0d: got %h, expected %h", i, gotData[i], modelBeat(base + i / 8, i % 8)); end
    end
  endtask

  task automatic test_reset_midblock();
    int b1 = addBlock(2'($urandom_range(0, 3)), 1'b0);
    int b2 = addBlock(2'($urandom_range(0, 3)), 1'b0);
    int b3;
    i_ready = 1'b0;
    applyStimulus(b1, 12);
    checks++; if (o_valid !== 1'b1) begin errors++; $display("[TB] FAIL rst_pre_valid: got %0b, expected 1", o_valid); end
    i_Reset = 1'b0;
    i_valid = 1'b1;
    i_data  = {$urandom, $urandom};
    @(negedge i_clk);
    i_Reset = 1'b1;
    i_valid = 1'b0;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_valid: got %0b, expected 0", o_valid); end
    checks++; if (o_data !== 64'h0) begin errors++; $display("[TB] FAIL rst_mid_data: got %h, expected 0", o_data); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_ready: got %0b, expected 1", o_ready); end
    checks++; if (o_last !== 1'b0 || o_mode !== 2'b00) begin errors++; $display("[TB] FAIL rst_mid_last_mode: got %0b/%b, expected 0/00", o_last, o_mode); end
    b3 = addBlock(2'($urandom_range(0, 3)), 1'b0);
    fork
      applyStimulus(b3, 8);
      collectBeats(8, 100);
    join
    for (int b = 0; b < gotData.size(); b++) begin
      checks++; if (gotData[b] !== modelBeat(b3, b)) begin errors++; $display("[TB] FAIL rst_new_data b%0d: got %h, expected %h", b, gotData[b], modelBeat(b3, b)); end
      checks++; if (gotMode[b] !== effMode(b3)) begin errors++; $display("[TB] FAIL rst_new_mode b%0d: got %b, expected %b", b, gotMode[b], effMode(b3)); end
    end
    checks++; if (firstValidT !== lastRowT[b3] + 5) begin errors++; $display("[TB] FAIL rst_new_latency: first valid at %0t, expected %0t", firstValidT, lastRowT[b3] + 5); end
    if (b2 != b1 + 1) $display("[TB] unexpected block index %0d", b2);
  endtask

  initial begin
    buildZigzag();
    rowsAccepted = 0;
    stallCycles  = 0;
    test_reset();
    test_zigzag();
    test_transpose();
    test_modes();
    test_back_to_back();
    test_backpressure();
    test_reset_midblock();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
